lz77_job_scheduler: RTL



---
 rtl/lz77_pkg.sv | 28 ++
 rtl/lz77_trip_fifo.sv | 52 +++++
 rtl/lz77_job_scheduler.sv | 171 +++++++++++++++++
 3 files changed

// File: rtl/lz77_pkg.sv
// Shared types and constants for the LZ77 encoder job path.
package lz77_pkg;

  localparam int unsigned STR_LEN  = 8192;
  localparam logic [7:0]  END_CHAR = 8'h24;
  localparam int unsigned OFF_W    = 5;
  localparam int unsigned LEN_W    = 5;
  localparam int unsigned CHAR_W   = 8;
  localparam int unsigned CH_W     = 2;

  typedef enum logic [2:0] {
    IDLE,
    CLR,
    LOAD,
    RUN,
    DRAIN,
    DONE
  } state_t;

  typedef struct packed {
    logic [CH_W-1:0]   ch;
    logic [OFF_W-1:0]  offset;
    logic [LEN_W-1:0]  len;
    logic [CHAR_W-1:0] char_nxt;
    logic              last;
  } triple_t;

endpackage

// File: rtl/lz77_trip_fifo.sv
// Synchronous triple FIFO; a push into a full FIFO succeeds when a pop happens in the same cycle.
module lz77_trip_fifo
  import lz77_pkg::*;
#(
  parameter int unsigned DEPTH = 4
) (
  input  logic    clk,
  input  logic    reset,
  input  logic    push,
  input  logic    pop,
  input  triple_t din,
  output logic    full,
  output logic    empty,
  output triple_t dout
);

  localparam int unsigned PW = $clog2(DEPTH);

  triple_t       mem [DEPTH];
  logic [PW-1:0] wr_ptr;
  logic [PW-1:0] rd_ptr;
  logic [PW:0]   count;
  logic          do_push;
  logic          do_pop;

  assign empty   = (count == '0);
  assign full    = (count == (PW+1)'(DEPTH));
  assign do_pop  = pop & ~empty;
  assign do_push = push & (~full | do_pop);
  assign dout    = mem[rd_ptr];

  always_ff @(posedge clk) begin
    if (do_push) mem[wr_ptr] <= din;
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + 1'b1;
      if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
      case ({do_push, do_pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

endmodule

// File: rtl/lz77_job_scheduler.sv
// Round-robin scheduler sharing one LZ77 encoder between NCH requesters:
// loads STR_LEN characters per job, then forwards tagged triples through a FIFO.
module lz77_job_scheduler #(
  parameter int unsigned NCH        = 2,
  parameter int unsigned AW         = 16,
  parameter int unsigned FIFO_DEPTH = 4,
  parameter int unsigned STR_LEN    = lz77_pkg::STR_LEN
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic [NCH-1:0]           req,
  input  logic [NCH*AW-1:0]        req_base,
  output logic [NCH-1:0]           done,
  output logic                     busy,
  output logic [AW-1:0]            mem_addr,
  input  logic [7:0]               mem_rdata,
  output logic                     enc_rst,
  output logic [7:0]               enc_chardata,
  input  logic                     enc_valid,
  input  logic                     enc_finish,
  input  logic [4:0]               enc_offset,
  input  logic [4:0]               enc_match_len,
  input  logic [7:0]               enc_char_nxt,
  output logic                     out_valid,
  input  logic                     out_ready,
  output logic [$clog2(NCH)-1:0]   out_ch,
  output logic [4:0]               out_offset,
  output logic [4:0]               out_len,
  output logic [7:0]               out_char,
  output logic                     out_last,
  output logic                     ovf
);

  import lz77_pkg::*;

  localparam int unsigned CHW = $clog2(NCH);
  localparam int unsigned KW  = $clog2(STR_LEN);

  state_t         state;
  state_t         state_nxt;
  logic [CHW-1:0] rr_q;
  logic [CHW-1:0] ch_q;
  logic [CHW-1:0] grant_ch;
  logic           grant_any;
  logic [KW-1:0]  k_q;
  logic           load_last;

  triple_t        fifo_din;
  triple_t        fifo_dout;
  logic           fifo_push;
  logic           fifo_pop;
  logic           fifo_full;
  logic           fifo_empty;

  // Cyclic search starting just after the last granted requester.
  always_comb begin
    int unsigned    idx;
    logic [CHW-1:0] idx_c;
    grant_any = 1'b0;
    grant_ch  = rr_q;
    idx       = 0;
    idx_c     = '0;
    for (int unsigned i = 1; i <= NCH; i++) begin
      idx = 32'(rr_q) + i;
      if (idx >= NCH) idx = idx - NCH;
      idx_c = CHW'(idx);
      if (!grant_any && req[idx_c]) begin
        grant_any = 1'b1;
        grant_ch  = idx_c;
      end
    end
  end

  assign load_last = (k_q == KW'(STR_LEN - 1));

  always_ff @(posedge clk or posedge reset) begin
    if (reset) state <= IDLE;
    else       state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    unique case (state)
      IDLE:    if (grant_any) state_nxt = CLR;
      CLR:     state_nxt = LOAD;
      LOAD:    if (load_last) state_nxt = RUN;
      RUN:     if (enc_finish) state_nxt = DRAIN;
      DRAIN:   if (fifo_empty) state_nxt = DONE;
      DONE:    state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_comb begin
    done = '0;
    if (state == DONE) done[ch_q] = 1'b1;
  end

  assign busy         = (state != IDLE);
  assign enc_chardata = (state == LOAD) ? mem_rdata : '0;

  // mem_addr doubles as the latched base: it is base in CLR and base+k+1 in LOAD.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      rr_q     <= CHW'(NCH - 1);
      ch_q     <= '0;
      mem_addr <= '0;
      k_q      <= '0;
      enc_rst  <= 1'b1;
      ovf      <= 1'b0;
    end else begin
      enc_rst <= (state_nxt == IDLE) || (state_nxt == CLR);
      case (state)
        IDLE: begin
          if (grant_any) begin
            ch_q     <= grant_ch;
            rr_q     <= grant_ch;
            mem_addr <= req_base[grant_ch*AW +: AW];
          end
        end
        CLR: begin
          mem_addr <= mem_addr + 1'b1;
          k_q      <= '0;
        end
        LOAD: begin
          if (!load_last) begin
            mem_addr <= mem_addr + 1'b1;
            k_q      <= k_q + 1'b1;
          end
        end
        RUN: begin
          if (fifo_push && fifo_full && !fifo_pop) ovf <= 1'b1;
        end
        default: ;
      endcase
    end
  end

  assign fifo_push = (state == RUN) && enc_valid;
  assign fifo_pop  = out_ready & ~fifo_empty;

  always_comb begin
    fifo_din          = '0;
    fifo_din.ch       = CH_W'(ch_q);
    fifo_din.offset   = enc_offset;
    fifo_din.len      = enc_match_len;
    fifo_din.char_nxt = enc_char_nxt;
    fifo_din.last     = (enc_char_nxt == END_CHAR);
  end

  lz77_trip_fifo #(
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk   (clk),
    .reset (reset),
    .push  (fifo_push),
    .pop   (fifo_pop),
    .din   (fifo_din),
    .full  (fifo_full),
    .empty (fifo_empty),
    .dout  (fifo_dout)
  );

  assign out_valid  = ~fifo_empty;
  assign out_ch     = CHW'(fifo_dout.ch);
  assign out_offset = fifo_dout.offset;
  assign out_len    = fifo_dout.len;
  assign out_char   = fifo_dout.char_nxt;
  assign out_last   = fifo_dout.last;

endmodule
